shift_seq: RTL

SHIFT_SEQ -- requirements
Module: shift_seq

---
 rtl/shift_seq.sv | 132 +++++++++++++
 1 files changed

// File: rtl/shift_seq.sv
// Multi-cycle barrel shifter: one conditional 2^k stage per cycle (k = 4..0), then a DONE cycle.
// Optional rotate-right for mode 11 is enabled by defining SHIFT_SEQ_ROTATE_EN.
module shift_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [4:0]  shamt,
    input  logic [1:0]  mode,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] MODE_SRL = 2'b00;
    localparam logic [1:0] MODE_SLL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    state_t      r_state;
    state_t      w_next_state;
    logic        r_busy;
    logic        r_done;
    logic        w_busy_d;
    logic        w_done_d;

    logic [2:0]  r_stage;
    logic [4:0]  r_shamt;
    logic [1:0]  r_mode;
    logic [31:0] r_work;
    logic [31:0] r_result;

    logic [5:0]  w_amt;
    logic [31:0] w_stage_val;
    logic [31:0] w_final;

    // State register; busy/done are registered copies of the output logic.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_busy  <= w_busy_d;
            r_done  <= w_done_d;
        end
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves the signal unassigned
        // (which would infer a latch).
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = S_SHIFT;
            S_SHIFT: if (r_stage == 3'd0) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy_d = (w_next_state != S_IDLE);
        w_done_d = (r_state == S_DONE);
    end

    // One stage of the shift network: distance 2^k for the current stage index.
    always_comb begin
        w_amt = 6'd1 << r_stage;
        case (r_mode)
            MODE_SRL: w_stage_val = r_work >> w_amt;
            MODE_SLL: w_stage_val = r_work << w_amt;
            MODE_SRA: w_stage_val = $unsigned($signed(r_work) >>> w_amt);
`ifdef SHIFT_SEQ_ROTATE_EN
            MODE_ROR: w_stage_val = (r_work >> w_amt) | (r_work << (6'd32 - w_amt));
`else
            MODE_ROR: w_stage_val = r_work;
`endif
            default:  w_stage_val = r_work;
        endcase
    end

`ifdef SHIFT_SEQ_ROTATE_EN
    assign w_final = r_work;
`else
    // Reserved mode still runs the full sequence but reports zero.
    assign w_final = (r_mode == MODE_ROR) ? 32'h0 : r_work;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stage  <= 3'd4;
            r_shamt  <= 5'd0;
            r_mode   <= MODE_SRL;
            r_work   <= 32'h0;
            r_result <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_work  <= a;
                        r_shamt <= shamt;
                        r_mode  <= mode;
                        r_stage <= 3'd4;
                    end
                end
                S_SHIFT: begin
                    if (r_shamt[r_stage]) r_work <= w_stage_val;
                    if (r_stage != 3'd0) r_stage <= r_stage - 3'd1;
                end
                S_DONE: begin
                    r_result <= w_final;
                    r_stage  <= 3'd4;
                end
                default: r_stage <= 3'd4;
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule
